// File: rtl/cpu_dbg_defs.sv
// Shared encodings for the CPU run/halt/step debug controller.
package cpu_dbg_defs;

  typedef enum logic [1:0] {
    ST_HALTED = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2
  } run_state_t;

  typedef enum logic [2:0] {
    CMD_NOP     = 3'd0,
    CMD_RUN     = 3'd1,
    CMD_HALT    = 3'd2,
    CMD_STEP    = 3'd3,
    CMD_SET_BP  = 3'd4,
    CMD_CLR_BP  = 3'd5,
    CMD_CLR_CNT = 3'd6,
    CMD_RSVD    = 3'd7
  } cmd_code_t;

  localparam logic [5:0] HALT_OP_DEFAULT = 6'b111111;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Debug/host command port: valid/ready handshake carrying a command code and data word.
interface cpu_run_ctrl_if;
  import cpu_dbg_defs::*;

  logic        cmd_valid;
  logic        cmd_ready;
  cmd_code_t   cmd_code;
  logic [31:0] cmd_data;

  modport master (output cmd_valid, output cmd_code, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_code, input cmd_data, output cmd_ready);
endinterface

// File: rtl/cpu_run_ctrl_run_counter.sv
// Free-running wrap-around event counter; clear beats increment in the same cycle.
module run_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step controller producing the CPU commit enable, with cycle/instruction counters.
// Breakpoint logic is present only when CPU_RUN_CTRL_BREAKPOINT_EN is defined.
module cpu_run_ctrl
  import cpu_dbg_defs::*;
#(
  parameter int         CNT_W   = 32,
  parameter logic [5:0] HALT_OP = HALT_OP_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  cpu_run_ctrl_if.slave    cmd,
  input  logic [31:0]      PC,
  input  logic [5:0]       op,
  output logic             cpu_en,
  output logic [1:0]       run_state,
  output logic             halt_hit,
  output logic             bp_hit,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  run_state_t state_q;
  logic       accept;
  logic       halt_stop;
  logic       bp_stop;
  logic       cnt_clr;

  assign cmd.cmd_ready = (state_q != ST_STEP);
  assign accept        = cmd.cmd_valid & cmd.cmd_ready;
  assign cnt_clr       = accept && (cmd.cmd_code == CMD_CLR_CNT);
  assign halt_stop     = (state_q != ST_HALTED) && (op == HALT_OP);
  assign run_state     = state_q;

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
  logic        bp_valid;
  logic        skip_bp;
  logic [31:0] bp_addr;

  // skip_bp lets a resumed RUN commit the instruction sitting on the breakpoint.
  assign bp_stop = (state_q == ST_RUN) && bp_valid && (PC == bp_addr) && !skip_bp && !halt_stop;

  always_ff @(posedge clk) begin
    if (reset) begin
      bp_valid <= 1'b0;
      bp_addr  <= '0;
      skip_bp  <= 1'b0;
      bp_hit   <= 1'b0;
    end else begin
      bp_hit <= bp_stop;
      if (state_q == ST_HALTED && accept && cmd.cmd_code == CMD_RUN) begin
        skip_bp <= 1'b1;
      end else if (state_q == ST_RUN) begin
        skip_bp <= 1'b0;
      end
      if (accept && cmd.cmd_code == CMD_SET_BP) begin
        bp_addr  <= cmd.cmd_data;
        bp_valid <= 1'b1;
      end else if (accept && cmd.cmd_code == CMD_CLR_BP) begin
        bp_valid <= 1'b0;
      end
    end
  end
`else
  logic unused_bp;
  assign unused_bp = ^{PC, cmd.cmd_data};
  assign bp_stop   = 1'b0;
  assign bp_hit    = 1'b0;
`endif

  assign cpu_en = !reset && (state_q != ST_HALTED) && !halt_stop && !bp_stop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_HALTED;
      halt_hit <= 1'b0;
    end else begin
      halt_hit <= halt_stop;
      unique case (state_q)
        ST_HALTED: begin
          if (accept && cmd.cmd_code == CMD_RUN) begin
            state_q <= ST_RUN;
          end else if (accept && cmd.cmd_code == CMD_STEP) begin
            state_q <= ST_STEP;
          end
        end
        ST_RUN: begin
          // Stop conditions outrank a HALT command; the HALT accept cycle still commits.
          if (halt_stop || bp_stop) begin
            state_q <= ST_HALTED;
          end else if (accept && cmd.cmd_code == CMD_HALT) begin
            state_q <= ST_HALTED;
          end
        end
        default: state_q <= ST_HALTED;
      endcase
    end
  end

  run_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (state_q != ST_HALTED),
    .clr   (cnt_clr),
    .count (cycle_cnt)
  );

  run_counter #(.CNT_W(CNT_W)) u_instr_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (cpu_en),
    .clr   (cnt_clr),
    .count (instr_cnt)
  );

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed vector bench for cpu_run_ctrl, using 4-bit counters so wrap-around is reachable.
module tb_cpu_run_ctrl;
  import cpu_dbg_defs::*;

  localparam int CNT_W = 4;

  typedef struct {
    bit          rst;
    bit          vld;
    cmd_code_t   code;
    logic [31:0] data;
    logic [31:0] pc;
    logic [5:0]  op;
    bit          en;
    bit          rdy;
    logic [1:0]  st;
    bit          hh;
    bit          bh;
    bit          chk_cnt;
    logic [3:0]  ic;
    logic [3:0]  cc;
  } vec_t;

  logic             clk;
  logic             reset;
  logic [31:0]      PC;
  logic [5:0]       op;
  logic             cpu_en;
  logic [1:0]       run_state;
  logic             halt_hit;
  logic             bp_hit;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instr_cnt;

  cpu_run_ctrl_if bus ();

  cpu_run_ctrl #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd       (bus.slave),
    .PC        (PC),
    .op        (op),
    .cpu_en    (cpu_en),
    .run_state (run_state),
    .halt_hit  (halt_hit),
    .bp_hit    (bp_hit),
    .cycle_cnt (cycle_cnt),
    .instr_cnt (instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vec_t tbl[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic void add(bit rst, bit vld, cmd_code_t code, logic [31:0] data,
                              logic [31:0] pc, logic [5:0] o, bit en, bit rdy,
                              logic [1:0] st, bit hh, bit bh, bit chk_cnt,
                              logic [3:0] ic, logic [3:0] cc);
    vec_t v;
    v.rst = rst; v.vld = vld; v.code = code; v.data = data; v.pc = pc; v.op = o;
    v.en = en; v.rdy = rdy; v.st = st; v.hh = hh; v.bh = bh;
    v.chk_cnt = chk_cnt; v.ic = ic; v.cc = cc;
    tbl.push_back(v);
  endfunction

  task automatic chk(input int idx, input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL vec %0d %s: got %0h expected %0h", idx, nm, act, exp);
    end
  endtask

  // Drive at the falling edge, compare 1ns later, well before the next rising edge.
  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    reset         = v.rst;
    bus.cmd_valid = v.vld;
    bus.cmd_code  = v.code;
    bus.cmd_data  = v.data;
    PC            = v.pc;
    op            = v.op;
    #1;
    n_vec++;
    chk(idx, "cpu_en",    32'(cpu_en),        32'(v.en));
    chk(idx, "cmd_ready", 32'(bus.cmd_ready), 32'(v.rdy));
    chk(idx, "run_state", 32'(run_state),     32'(v.st));
    chk(idx, "halt_hit",  32'(halt_hit),      32'(v.hh));
    chk(idx, "bp_hit",    32'(bp_hit),        32'(v.bh));
    if (v.chk_cnt) begin
      chk(idx, "instr_cnt", 32'(instr_cnt), 32'(v.ic));
      chk(idx, "cycle_cnt", 32'(cycle_cnt), 32'(v.cc));
    end
  endtask

  localparam logic [5:0] HOP = 6'b111111;

  initial begin
    reset = 1'b1; bus.cmd_valid = 1'b0; bus.cmd_code = CMD_NOP; bus.cmd_data = '0;
    PC = '0; op = '0;
    repeat (2) @(posedge clk);

    //   rst vld code         data   pc     op   en rdy st hh bh chk ic cc
    // Reset state, RUN for five commits, then HALT (sixth commit in accept cycle).
    add(0, 1, CMD_RUN,     0, 32'h0,  0,   0, 1, 0, 0, 0, 1, 0, 0);
    add(0, 0, CMD_NOP,     0, 32'h0,  0,   1, 1, 1, 0, 0, 1, 0, 0);
    add(0, 0, CMD_NOP,     0, 32'h4,  0,   1, 1, 1, 0, 0, 1, 1, 1);
    add(0, 0, CMD_NOP,     0, 32'h8,  0,   1, 1, 1, 0, 0, 1, 2, 2);
    add(0, 0, CMD_NOP,     0, 32'hC,  0,   1, 1, 1, 0, 0, 1, 3, 3);
    add(0, 0, CMD_NOP,     0, 32'h10, 0,   1, 1, 1, 0, 0, 1, 4, 4);
    add(0, 1, CMD_HALT,    0, 32'h14, 0,   1, 1, 1, 0, 0, 1, 5, 5);
    add(0, 0, CMD_NOP,     0, 32'h18, 0,   0, 1, 0, 0, 0, 1, 6, 6);
    add(0, 1, CMD_CLR_CNT, 0, 32'h18, 0,   0, 1, 0, 0, 0, 1, 6, 6);
    // Single step at 0x0C; a RUN offered during STEP is not accepted.
    add(0, 1, CMD_STEP,    0, 32'hC,  0,   0, 1, 0, 0, 0, 1, 0, 0);
    add(0, 1, CMD_RUN,     0, 32'hC,  0,   1, 0, 2, 0, 0, 1, 0, 0);
    add(0, 0, CMD_NOP,     0, 32'h10, 0,   0, 1, 0, 0, 0, 1, 1, 1);
    // Halt opcode in RUN, then STEP onto the same halt opcode.
    add(0, 1, CMD_RUN,     0, 32'h1C, 0,   0, 1, 0, 0, 0, 1, 1, 1);
    add(0, 0, CMD_NOP,     0, 32'h1C, 0,   1, 1, 1, 0, 0, 1, 1, 1);
    add(0, 0, CMD_NOP,     0, 32'h20, HOP, 0, 1, 1, 0, 0, 1, 2, 2);
    add(0, 0, CMD_NOP,     0, 32'h20, HOP, 0, 1, 0, 1, 0, 1, 2, 3);
    add(0, 1, CMD_STEP,    0, 32'h20, HOP, 0, 1, 0, 0, 0, 1, 2, 3);
    add(0, 0, CMD_NOP,     0, 32'h20, HOP, 0, 0, 2, 0, 0, 1, 2, 3);
    add(0, 0, CMD_NOP,     0, 32'h20, HOP, 0, 1, 0, 1, 0, 1, 2, 4);
    add(0, 0, CMD_NOP,     0, 32'h20, 0,   0, 1, 0, 0, 0, 1, 2, 4);
    // CLR_CNT in a commit cycle: clear wins over increment.
    add(0, 1, CMD_RUN,     0, 32'h0,  0,   0, 1, 0, 0, 0, 1, 2, 4);
    add(0, 0, CMD_NOP,     0, 32'h0,  0,   1, 1, 1, 0, 0, 1, 2, 4);
    add(0, 1, CMD_CLR_CNT, 0, 32'h4,  0,   1, 1, 1, 0, 0, 1, 3, 5);
    add(0, 0, CMD_NOP,     0, 32'h8,  0,   1, 1, 1, 0, 0, 1, 0, 0);
    add(0, 1, CMD_HALT,    0, 32'hC,  0,   1, 1, 1, 0, 0, 1, 1, 1);
    add(0, 0, CMD_NOP,     0, 32'h10, 0,   0, 1, 0, 0, 0, 1, 2, 2);
    // Reserved code is accepted and ignored.
    add(0, 1, CMD_RSVD,    0, 32'h10, 0,   0, 1, 0, 0, 0, 1, 2, 2);
    // Wrap: 17 commits on a 4-bit counter leave instr_cnt = 1.
    add(0, 1, CMD_CLR_CNT, 0, 32'h0,  0,   0, 1, 0, 0, 0, 1, 2, 2);
    add(0, 1, CMD_RUN,     0, 32'h0,  0,   0, 1, 0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 16; k++)
      add(0, 0, CMD_NOP,   0, 32'(4 * k), 0, 1, 1, 1, 0, 0, 1, 4'(k), 4'(k));
    add(0, 1, CMD_HALT,    0, 32'h40, 0,   1, 1, 1, 0, 0, 1, 0, 0);
    add(0, 0, CMD_NOP,     0, 32'h44, 0,   0, 1, 0, 0, 0, 1, 1, 1);
    // Breakpoint at 0x10.
    add(0, 1, CMD_CLR_CNT, 0, 32'h0,  0,   0, 1, 0, 0, 0, 1, 1, 1);
    add(0, 1, CMD_SET_BP, 32'h10, 32'h0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
    add(0, 1, CMD_RUN,     0, 32'h0,  0,   0, 1, 0, 0, 0, 1, 0, 0);
    add(0, 0, CMD_NOP,     0, 32'h0,  0,   1, 1, 1, 0, 0, 1, 0, 0);
    add(0, 0, CMD_NOP,     0, 32'h4,  0,   1, 1, 1, 0, 0, 1, 1, 1);
    add(0, 0, CMD_NOP,     0, 32'h8,  0,   1, 1, 1, 0, 0, 1, 2, 2);
    add(0, 0, CMD_NOP,     0, 32'hC,  0,   1, 1, 1, 0, 0, 1, 3, 3);
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    add(0, 0, CMD_NOP,     0, 32'h10, 0,   0, 1, 1, 0, 0, 1, 4, 4);
    add(0, 0, CMD_NOP,     0, 32'h10, 0,   0, 1, 0, 0, 1, 1, 4, 5);
    add(0, 1, CMD_RUN,     0, 32'h10, 0,   0, 1, 0, 0, 0, 1, 4, 5);
    add(0, 0, CMD_NOP,     0, 32'h10, 0,   1, 1, 1, 0, 0, 1, 4, 5);
    add(0, 0, CMD_NOP,     0, 32'h14, 0,   1, 1, 1, 0, 0, 1, 5, 6);
    add(0, 1, CMD_HALT,    0, 32'h18, 0,   1, 1, 1, 0, 0, 1, 6, 7);
    add(0, 1, CMD_CLR_BP,  0, 32'hC,  0,   0, 1, 0, 0, 0, 1, 7, 8);
    add(0, 1, CMD_RUN,     0, 32'hC,  0,   0, 1, 0, 0, 0, 1, 7, 8);
    add(0, 0, CMD_NOP,     0, 32'hC,  0,   1, 1, 1, 0, 0, 1, 7, 8);
    add(0, 0, CMD_NOP,     0, 32'h10, 0,   1, 1, 1, 0, 0, 1, 8, 9);
    add(0, 1, CMD_HALT,    0, 32'h14, 0,   1, 1, 1, 0, 0, 1, 9, 10);
    add(0, 0, CMD_NOP,     0, 32'h18, 0,   0, 1, 0, 0, 0, 1, 10, 11);
`else
    // Without breakpoint support the SET_BP is ignored and 0x10 commits.
    add(0, 0, CMD_NOP,     0, 32'h10, 0,   1, 1, 1, 0, 0, 1, 4, 4);
    add(0, 1, CMD_HALT,    0, 32'h14, 0,   1, 1, 1, 0, 0, 1, 5, 5);
    add(0, 0, CMD_NOP,     0, 32'h18, 0,   0, 1, 0, 0, 0, 1, 6, 6);
`endif
    // Reset mid-RUN: cpu_en forced low, then registers (incl. breakpoint) cleared.
    add(0, 1, CMD_CLR_CNT, 0, 32'h0,  0,   0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, CMD_SET_BP, 32'h40, 32'h0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
    add(0, 1, CMD_RUN,     0, 32'h3C, 0,   0, 1, 0, 0, 0, 1, 0, 0);
    add(0, 0, CMD_NOP,     0, 32'h3C, 0,   1, 1, 1, 0, 0, 1, 0, 0);
    add(1, 0, CMD_NOP,     0, 32'h40, 0,   0, 1, 1, 0, 0, 1, 1, 1);
    add(0, 1, CMD_RUN,     0, 32'h40, 0,   0, 1, 0, 0, 0, 1, 0, 0);
    add(0, 0, CMD_NOP,     0, 32'h40, 0,   1, 1, 1, 0, 0, 1, 0, 0);
    add(0, 0, CMD_NOP,     0, 32'h40, 0,   1, 1, 1, 0, 0, 1, 1, 1);
    add(0, 1, CMD_HALT,    0, 32'h44, 0,   1, 1, 1, 0, 0, 1, 2, 2);
    add(0, 0, CMD_NOP,     0, 32'h48, 0,   0, 1, 0, 0, 0, 1, 3, 3);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run/halt/single-step controller for the single-cycle CPU. It owns a single commit-enable, `cpu_en`. The top level ANDs `cpu_en` into `PCwrt`, `regWrt` and `memWrt`, so every cycle with `cpu_en=1` commits exactly one instruction at `PC`. The block takes commands from a debug/host port over a valid/ready handshake, stops on a halt opcode or on a PC breakpoint, and keeps cycle and retired-instruction counters.

## Interface
Parameters:
- `CNT_W`, 32: width of `cycle_cnt` and `instr_cnt`.
- `HALT_OP`, 6'b111111: opcode that stops the CPU.

Ports:
- `clk`  in  1: clock. One clock domain.
- `reset`  in  1: synchronous, active-high reset.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: controller can accept a command.
- `cmd_code`  in  3: 0 NOP, 1 RUN, 2 HALT, 3 STEP, 4 SET_BP, 5 CLR_BP, 6 CLR_CNT, 7 reserved.
- `cmd_data`  in  32: breakpoint address for SET_BP.
- `PC`  in  32: current PC from the NPC unit.
- `op`  in  6: `instruction[31:26]` of the instruction at `PC`.
- `cpu_en`  out  1: commit enable. Combinational.
- `run_state`  out  2: 0 HALTED, 1 RUN, 2 STEP.
- `halt_hit`  out  1: one-cycle pulse when a halt opcode stops the CPU.
- `bp_hit`  out  1: one-cycle pulse when a breakpoint stops the CPU.
- `cycle_cnt`  out  CNT_W: count of non-HALTED cycles.
- `instr_cnt`  out  CNT_W: count of committed instructions.

## Operation
- **Reset values:** `run_state=HALTED`, `bp_valid=0`, `bp_addr=0`, `skip_bp=0`, both counters 0, `halt_hit=0`, `bp_hit=0`. `cpu_en=0` while in HALTED.
- **Accept rule:** a command is accepted when `cmd_valid & cmd_ready`. `cmd_ready = (run_state != STEP)`.
- **HALTED:**
  - RUN goes to RUN and sets `skip_bp=1`.
  - STEP goes to STEP.
  - HALT and NOP have no effect.
- **RUN:**
  - `cpu_en=1` unless a stop condition holds.
  - Halt opcode: if `op==HALT_OP`, then `cpu_en=0`, go to HALTED, pulse `halt_hit` on the next cycle.
  - Breakpoint: else if `bp_valid & PC==bp_addr & !skip_bp`, then `cpu_en=0`, go to HALTED, pulse `bp_hit` on the next cycle. The instruction at the breakpoint is not executed.
  - `skip_bp` clears after the first RUN cycle.
  - Accepted HALT goes to HALTED next cycle. The instruction in the accept cycle still commits.
  - RUN and STEP are accepted and ignored.
- **STEP:** lasts exactly one cycle, then returns to HALTED.
  - `cpu_en=1` unless `op==HALT_OP`, in which case `cpu_en=0` and `halt_hit` pulses.
  - Breakpoints are ignored in STEP.
- **Breakpoint and counter commands:**
  - SET_BP: `bp_addr<=cmd_data`, `bp_valid<=1`.
  - CLR_BP: `bp_valid<=0`.
  - CLR_CNT: zeroes both counters.
  - All three are legal in any state except STEP; they do not change `run_state`.
  - Code 7 is accepted and ignored.
- **Counters:**
  - `cycle_cnt` increments when `run_state!=HALTED`.
  - `instr_cnt` increments when `cpu_en=1`.
  - Both wrap modulo 2^CNT_W with no saturation.
  - CLR_CNT in the same cycle as an increment: the counter is 0 next cycle (clear wins).
- **Priority within one cycle:** `reset` > halt opcode > breakpoint > accepted command.

## Timing
- `cpu_en` is combinational from registered state, `skip_bp`, `bp_*`, `PC` and `op`. It has no register stage, so the commit happens in the same cycle.
- RUN command accepted in cycle N: first commit in cycle N+1.
- STEP command accepted in cycle N: exactly one commit in cycle N+1; HALTED in N+2.
- Breakpoint condition true in cycle N: `cpu_en=0` in N; `run_state=HALTED` and `bp_hit=1` in N+1.
- Reset asserted mid-RUN or mid-STEP: in the reset cycle `cpu_en` is forced 0 and all registers take their reset values at the next edge.
- `cmd_ready` deasserts only for the single STEP cycle.

## Configuration
- Macro: `CPU_RUN_CTRL_BREAKPOINT_EN`.
- **Defined:** `bp_addr`/`bp_valid` registers, the PC compare, `skip_bp` and `bp_hit` are present as described above.
- **Undefined:**
  - No breakpoint logic.
  - SET_BP and CLR_BP are accepted and ignored.
  - `bp_hit` is tied 0.
  - RUN stops only on HALT or the halt opcode.

## Structure
- Shared header/package `cpu_dbg_defs` holds:
  - `run_state` encodings (HALTED/RUN/STEP),
  - `cmd_code` encodings 0..7,
  - the `HALT_OP` default.
- One natural sub-module: `run_counter`, instantiated twice, with inputs `clk`, `reset`, `inc`, `clr` and output `count[CNT_W-1:0]`. Clear has priority over increment.
- The FSM, the stop logic and command decode stay in `cpu_run_ctrl`.

## Test plan
- **Reset:** assert `reset` for 2 cycles, then RUN with `op=0` for 5 cycles, then HALT. Expect `instr_cnt=6`: the five RUN cycles plus the HALT accept cycle. `run_state` returns to 0.
- **Single step:** from HALTED, STEP with `PC=0x0C` → `cpu_en=1` for exactly one cycle, `cmd_ready=0` in that cycle, `instr_cnt` +1, `run_state=0` after.
- **Breakpoint:** SET_BP 0x10, then RUN with PC advancing by 4 from 0 → commits at 0, 4, 8, 0xC; `cpu_en=0` at 0x10; `bp_hit` pulses; `instr_cnt=4`. A second RUN commits 0x10 (skip) and continues.
- **Halt opcode:** RUN, then present `op=6'b111111` at PC 0x20 → `cpu_en=0`, `halt_hit` pulses, HALTED. STEP at the same PC → no commit, `halt_hit` pulses again.
- **Clear vs increment and wrap:** with `CNT_W=4`, run 17 commits → `instr_cnt=1`. Issue CLR_CNT in a commit cycle → both counters read 0 next cycle.
- **Reset mid-RUN:** assert `reset` while `cpu_en=1` → `cpu_en=0` in that cycle; next cycle HALTED, counters 0, `bp_valid=0`.
